btn_event_arbiter: RTL and testbench

- Collects the 2-bit press codes from NUM_BTN button-detector instances and grants them round-robin into a small event FIFO.
- Presents the FIFO as a single valid/ready event stream for the mode/menu controller downstream.
- Holds at most one pending event per button so that back-pressure never loses events silently.
- Press codes: 0 = none, 1 = short press or auto-repeat tick, 2 = long press.

---
 rtl/btn_event_arbiter_if.sv | 19 +
 rtl/btn_event_arbiter.sv | 147 ++++++++++++++
 tb/tb_btn_event_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/btn_event_arbiter_if.sv
// rtl/btn_event_arbiter_if.sv - event stream bundle between the button arbiter and its consumer
//
// Signals:
//   evt_valid  head of the event FIFO holds an event
//   evt_code   press code of the head event (1 = short/repeat, 2 = long)
//   evt_id     channel index of the head event
//   evt_ready  consumer accepts the head event
// Modports: master (arbiter side), slave (consumer side).
interface btn_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic [1:0]      evt_code;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;

    modport master (output evt_valid, output evt_code, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_code, input evt_id, output evt_ready);
endinterface

// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - round-robin arbiter of button press codes into a show-ahead event FIFO
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   btn_state  per-channel 2-bit press pulses, channel i at [2i+1:2i]
//   evt        event stream (master modport of btn_event_arbiter_if)
//   pending    per-channel pending-event flags
//   overflow   sticky flag, an event was dropped
// Configuration macro: BTN_ARB_COALESCE_EN
//   defined   - a second event on a pending channel merges as max(old, new)
//   undefined - a second event on a pending channel is dropped and overflow sets
module btn_event_arbiter #(
    parameter int NUM_BTN    = 4,
    parameter int ID_W       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2*NUM_BTN-1:0]   btn_state,
    btn_event_arbiter_if.master    evt,
    output logic [NUM_BTN-1:0]     pending,
    output logic                   overflow
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [1:0]         code_q [NUM_BTN];
    logic [1:0]         code_d [NUM_BTN];
    logic [ID_W-1:0]    ptr_q;
    logic               ovf_q, ovf_d;

    logic [ID_W+1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         hold_code_q;
    logic [ID_W-1:0]    hold_id_q;

    logic               pop, can_push, gnt_vld;
    logic [ID_W-1:0]    gnt_idx;
    logic [1:0]         gnt_code;
    logic [ID_W+1:0]    head;

    function automatic int wrap_idx(input int v);
        return (v >= NUM_BTN) ? v - NUM_BTN : v;
    endfunction

    assign evt.evt_valid = (cnt_q != '0);
    assign pop           = evt.evt_valid && evt.evt_ready;
    // A full FIFO can still take a push on the cycle it is popped.
    assign can_push      = (int'(cnt_q) < FIFO_DEPTH) || pop;
    assign head          = mem_q[rd_q];

    // Outputs keep the last shown entry while the FIFO is empty.
    assign evt.evt_code  = evt.evt_valid ? head[ID_W+1:ID_W] : hold_code_q;
    assign evt.evt_id    = evt.evt_valid ? head[ID_W-1:0]    : hold_id_q;
    assign pending       = pend_q;
    assign overflow      = ovf_q;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        gnt_code = 2'd0;
        if (can_push) begin
            for (int k = 1; k <= NUM_BTN; k++) begin
                if (!gnt_vld && pend_q[wrap_idx(int'(ptr_q) + k)]) begin
                    gnt_vld  = 1'b1;
                    gnt_idx  = ID_W'(wrap_idx(int'(ptr_q) + k));
                    gnt_code = code_q[wrap_idx(int'(ptr_q) + k)];
                end
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            code_d[i] = code_q[i];
            if (gnt_vld && (int'(gnt_idx) == i)) begin
                // Granted this cycle: old code goes out, a new pulse refills the slot.
                if ((btn_state[2*i +: 2] == 2'd1) || (btn_state[2*i +: 2] == 2'd2)) begin
                    pend_d[i] = 1'b1;
                    code_d[i] = btn_state[2*i +: 2];
                end else begin
                    pend_d[i] = 1'b0;
                    code_d[i] = 2'd0;
                end
            end else if ((btn_state[2*i +: 2] == 2'd1) || (btn_state[2*i +: 2] == 2'd2)) begin
                if (!pend_q[i]) begin
                    pend_d[i] = 1'b1;
                    code_d[i] = btn_state[2*i +: 2];
                end else begin
`ifdef BTN_ARB_COALESCE_EN
                    if (btn_state[2*i +: 2] > code_q[i]) begin
                        code_d[i] = btn_state[2*i +: 2];
                    end
`else
                    ovf_d = 1'b1;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q      <= '0;
            ptr_q       <= ID_W'(NUM_BTN - 1);
            ovf_q       <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            hold_code_q <= 2'd0;
            hold_id_q   <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                code_q[i] <= 2'd0;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            hold_code_q <= evt.evt_code;
            hold_id_q   <= evt.evt_id;
            for (int i = 0; i < NUM_BTN; i++) begin
                code_q[i] <= code_d[i];
            end
            if (gnt_vld) begin
                mem_q[wr_q] <= {gnt_code, gnt_idx};
                wr_q        <= wr_q + AW'(1);
                ptr_q       <= gnt_idx;
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({gnt_vld, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb/tb_btn_event_arbiter.sv - self-checking bench for btn_event_arbiter
module tb_btn_event_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btn_state = 8'h00;
    logic [3:0] pending;
    logic       overflow;

    int n_chk  = 0;
    int n_fail = 0;
    logic [3:0] sb_q [$];
    logic [3:0] sb_e;

`ifdef BTN_ARB_COALESCE_EN
    localparam logic       EXP_OVF  = 1'b0;
    localparam logic [1:0] EXP_MERG = 2'd2;
`else
    localparam logic       EXP_OVF  = 1'b1;
    localparam logic [1:0] EXP_MERG = 2'd1;
`endif

    always #5 clk = ~clk;

    btn_event_arbiter_if #(.ID_W(2)) evt_if ();

    btn_event_arbiter #(.NUM_BTN(4), .ID_W(2), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .btn_state (btn_state),
        .evt       (evt_if),
        .pending   (pending),
        .overflow  (overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply inputs for one cycle; returns 1 time unit after the sampling edge.
    task automatic drive(input logic [7:0] b, input logic r);
        btn_state        = b;
        evt_if.evt_ready = r;
        @(posedge clk);
        #1;
        btn_state = 8'h00;
    endtask

    // Scoreboard: every accepted head must match the next expected event.
    always @(negedge clk) begin
        if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected none", {evt_if.evt_code, evt_if.evt_id});
            end else begin
                sb_e = sb_q.pop_front();
                chk("pop_head", {28'd0, evt_if.evt_code, evt_if.evt_id}, {28'd0, sb_e});
            end
        end
    end

    typedef struct {
        logic [7:0] btn;
        logic       rdy;
        logic       v;
        logic [3:0] pend;
        logic [1:0] code;
        logic [1:0] id;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'h55, 1'b0, 1'b0, 4'b1111, 2'd0, 2'd0};
        tbl[1]  = '{8'h00, 1'b0, 1'b1, 4'b1110, 2'd1, 2'd0};
        tbl[2]  = '{8'h00, 1'b0, 1'b1, 4'b1100, 2'd1, 2'd0};
        tbl[3]  = '{8'h00, 1'b0, 1'b1, 4'b1000, 2'd1, 2'd0};
        tbl[4]  = '{8'h00, 1'b0, 1'b1, 4'b0000, 2'd1, 2'd0};
        tbl[5]  = '{8'h05, 1'b1, 1'b1, 4'b0011, 2'd1, 2'd1};
        tbl[6]  = '{8'h00, 1'b1, 1'b1, 4'b0010, 2'd1, 2'd2};
        tbl[7]  = '{8'h00, 1'b1, 1'b1, 4'b0000, 2'd1, 2'd3};
        tbl[8]  = '{8'h00, 1'b1, 1'b1, 4'b0000, 2'd1, 2'd0};
        tbl[9]  = '{8'h00, 1'b1, 1'b1, 4'b0000, 2'd1, 2'd1};
        tbl[10] = '{8'h00, 1'b1, 1'b0, 4'b0000, 2'd1, 2'd1};

        evt_if.evt_ready = 1'b0;
        #2;
        chk("rst_valid", evt_if.evt_valid, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_code_id", {evt_if.evt_code, evt_if.evt_id}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single short press on channel 2, two-cycle latency, then popped.
        sb_q.push_back({2'd1, 2'd2});
        drive(8'h10, 1'b1);
        chk("t1_pend", pending, 4'b0100);
        chk("t1_valid0", evt_if.evt_valid, 0);
        drive(8'h00, 1'b1);
        chk("t1_valid1", evt_if.evt_valid, 1);
        chk("t1_head", {evt_if.evt_code, evt_if.evt_id}, {2'd1, 2'd2});
        chk("t1_pend_clr", pending, 0);
        drive(8'h00, 1'b1);
        chk("t1_empty", evt_if.evt_valid, 0);

        // Fresh pointer: all-channel burst, then channels 0/1 with pointer at 3.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.push_back({2'd1, 2'd0});
        sb_q.push_back({2'd1, 2'd1});
        sb_q.push_back({2'd1, 2'd2});
        sb_q.push_back({2'd1, 2'd3});
        sb_q.push_back({2'd1, 2'd0});
        sb_q.push_back({2'd1, 2'd1});
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].btn, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), evt_if.evt_valid, tbl[i].v);
            chk($sformatf("tbl%0d_pend", i), pending, tbl[i].pend);
            chk($sformatf("tbl%0d_head", i), {evt_if.evt_code, evt_if.evt_id}, {tbl[i].code, tbl[i].id});
        end

        // Fill to full (pointer at 1, so order 2,3,0,1), then stall channel 1.
        sb_q.push_back({2'd1, 2'd2});
        sb_q.push_back({2'd1, 2'd3});
        sb_q.push_back({2'd1, 2'd0});
        sb_q.push_back({2'd1, 2'd1});
        drive(8'h55, 1'b0);
        repeat (4) drive(8'h00, 1'b0);
        chk("t3_pend_drained", pending, 0);
        drive(8'h08, 1'b0);
        sb_q.push_back({2'd2, 2'd1});
        drive(8'h00, 1'b0);
        chk("t3_stall_pend", pending, 4'b0010);
        chk("t3_stall_head", {evt_if.evt_code, evt_if.evt_id}, {2'd1, 2'd2});
        drive(8'h00, 1'b1);
        chk("t3_popush_pend", pending, 0);
        chk("t3_popush_head", {evt_if.evt_code, evt_if.evt_id}, {2'd1, 2'd3});

        // FIFO still full: second event on a pending channel.
        drive(8'h40, 1'b0);
        drive(8'h00, 1'b0);
        chk("t4_still_pend", pending, 4'b1000);
        drive(8'h80, 1'b0);
        chk("t4_overflow", overflow, EXP_OVF);
        sb_q.push_back({EXP_MERG, 2'd3});
        repeat (6) drive(8'h00, 1'b1);
        chk("t4_drained", evt_if.evt_valid, 0);
        chk("t4_pend", pending, 0);
        chk("t4_ovf_sticky", overflow, EXP_OVF);
        chk("t4_sb_empty", sb_q.size(), 0);

        // Illegal code, then asynchronous reset with events queued.
        drive(8'h03, 1'b0);
        chk("t5_illegal_pend", pending, 0);
        drive(8'h00, 1'b0);
        chk("t5_illegal_valid", evt_if.evt_valid, 0);
        drive(8'h54, 1'b0);
        repeat (4) drive(8'h00, 1'b0);
        chk("t5_queued", evt_if.evt_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", evt_if.evt_valid, 0);
        chk("t5_rst_pend", pending, 0);
        chk("t5_rst_ovf", overflow, 0);
        chk("t5_rst_head", {evt_if.evt_code, evt_if.evt_id}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.push_back({2'd1, 2'd0});
        sb_q.push_back({2'd1, 2'd3});
        drive(8'h41, 1'b1);
        chk("t5_pend", pending, 4'b1001);
        drive(8'h00, 1'b1);
        chk("t5_first_id", {evt_if.evt_valid, evt_if.evt_id}, {1'b1, 2'd0});
        repeat (3) drive(8'h00, 1'b1);
        chk("t5_end_valid", evt_if.evt_valid, 0);
        chk("t5_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
